// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: one-entry retire slot, load wait, register file write port, bypass info
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [63:0] in_alu_result,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData,
  input  logic [4:0]  fwd_rs1,
  input  logic [4:0]  fwd_rs2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic        fwd_pend1,
  output logic        fwd_pend2,
  output logic [63:0] fwd_data,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FULL     = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic [63:0] r_data;
  logic [31:0] r_retire_count;

  logic w_accept;
  logic w_in_is_load;
  logic w_eff_we;
  logic w_load_return;

  assign w_accept      = in_valid & in_ready;
  // Only a writing load needs to wait; a non-writing "load" retires like an ALU op.
  assign w_in_is_load  = in_mem_to_reg & in_reg_write;
  // X31 is the zero register: such writes retire but never reach the file.
  assign w_eff_we      = r_reg_write & (r_rd != 5'd31);
  assign w_load_return = (r_state == S_WAIT_MEM) & r_mem_to_reg & mem_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY, S_FULL: begin
        if (w_accept) begin
          w_state_next = w_in_is_load ? S_WAIT_MEM : S_FULL;
        end else begin
          w_state_next = S_EMPTY;
        end
      end
      S_WAIT_MEM: begin
        if (w_load_return) begin
          w_state_next = S_FULL;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_EMPTY) | (r_state == S_FULL);
    RegWrite  = (r_state == S_FULL) & w_eff_we;
    fwd_hit1  = (r_state == S_FULL) & w_eff_we & (r_rd == fwd_rs1);
    fwd_hit2  = (r_state == S_FULL) & w_eff_we & (r_rd == fwd_rs2);
    fwd_pend1 = (r_state == S_WAIT_MEM) & w_eff_we & (r_rd == fwd_rs1);
    fwd_pend2 = (r_state == S_WAIT_MEM) & w_eff_we & (r_rd == fwd_rs2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_data       <= 64'd0;
    end else if (w_accept) begin
      r_rd         <= in_rd;
      r_reg_write  <= in_reg_write;
      r_mem_to_reg <= w_in_is_load;
      r_data       <= w_in_is_load ? 64'd0 : in_alu_result;
    end else if (w_load_return) begin
      r_data <= mem_rdata;
    end
  end

  // Every FULL cycle is a retirement, whether or not it writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_count <= 32'd0;
    end else if (r_state == S_FULL) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign WriteRegister = r_rd;
  assign WriteData     = r_data;
  assign fwd_data      = r_data;
  assign retire_count  = r_retire_count;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage: vector table, corner sequences, random vs reference model
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [63:0] in_alu_result;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_hit1, fwd_hit2, fwd_pend1, fwd_pend2;
  logic [63:0] fwd_data;
  logic [31:0] retire_count;

  int n_vec = 0;
  int n_bad = 0;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_pend1(fwd_pend1), .fwd_pend2(fwd_pend2),
    .fwd_data(fwd_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [63:0] alu;
    logic        rv;
    logic [63:0] rdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [63:0] e_wd;
    logic        e_rdy;
    logic        e_h1, e_p1, e_h2, e_p2;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [4:0] rd, input logic rw, input logic m2r,
                     input logic [63:0] alu, input logic rv, input logic [63:0] rdata,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic we, input logic [4:0] wr, input logic [63:0] wd, input logic rdy,
                     input logic h1, input logic p1, input logic h2, input logic p2,
                     input logic [31:0] cnt);
    vec_t t;
    t.v = v; t.rd = rd; t.rw = rw; t.m2r = m2r; t.alu = alu; t.rv = rv; t.rdata = rdata;
    t.rs1 = rs1; t.rs2 = rs2; t.e_we = we; t.e_wr = wr; t.e_wd = wd; t.e_rdy = rdy;
    t.e_h1 = h1; t.e_p1 = p1; t.e_h2 = h2; t.e_p2 = p2; t.e_cnt = cnt;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic we, input logic [4:0] wr,
                           input logic [63:0] wd, input logic rdy, input logic h1, input logic p1,
                           input logic h2, input logic p2, input logic [31:0] cnt);
    check({tag, ".RegWrite"},      RegWrite,      we);
    check({tag, ".WriteRegister"}, WriteRegister, wr);
    check({tag, ".WriteData"},     WriteData,     wd);
    check({tag, ".fwd_data"},      fwd_data,      wd);
    check({tag, ".in_ready"},      in_ready,      rdy);
    check({tag, ".fwd_hit1"},      fwd_hit1,      h1);
    check({tag, ".fwd_pend1"},     fwd_pend1,     p1);
    check({tag, ".fwd_hit2"},      fwd_hit2,      h2);
    check({tag, ".fwd_pend2"},     fwd_pend2,     p2);
    check({tag, ".retire_count"},  retire_count,  cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic [63:0] alu, input logic rv, input logic [63:0] rdata,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid = v; in_rd = rd; in_reg_write = rw; in_mem_to_reg = m2r; in_alu_result = alu;
    mem_rvalid = rv; mem_rdata = rdata; fwd_rs1 = rs1; fwd_rs2 = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: a one-entry holding slot with "occupied" and "waiting for data" flags.
  logic        m_have, m_wait, m_rw;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_have = 0; m_wait = 0; m_rw = 0; m_rd = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic retiring;
    logic ready;
    retiring = m_have && !m_wait;
    ready    = !m_wait;
    if (reset) begin
      model_reset();
    end else begin
      if (retiring) m_cnt = m_cnt + 1;
      if (in_valid && ready) begin
        m_have = 1;
        m_rd   = in_rd;
        m_rw   = in_reg_write;
        m_wait = in_mem_to_reg && in_reg_write;
        m_data = m_wait ? 64'd0 : in_alu_result;
      end else if (retiring) begin
        m_have = 0;
      end else if (m_wait && mem_rvalid) begin
        m_data = mem_rdata;
        m_wait = 0;
      end
    end
  endtask

  task automatic model_check();
    logic writes, full;
    writes = m_rw && (m_rd != 5'd31);
    full   = m_have && !m_wait;
    check_all("rnd", full && writes, m_rd, m_data, !m_wait,
              full && writes && (m_rd == fwd_rs1), m_wait && writes && (m_rd == fwd_rs1),
              full && writes && (m_rd == fwd_rs2), m_wait && writes && (m_rd == fwd_rs2), m_cnt);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    check_all("reset", 0, 0, 0, 1, 0, 0, 0, 0, 0);

    //   v  rd rw m2r alu                  rv rdata                   rs1 rs2 | we wr wd                    rdy h1 p1 h2 p2 cnt
    add(1,  5, 1, 0, 64'h1234,             0, 0,                      5,  0,   1, 5, 64'h1234,             1,  1, 0, 0, 0, 0);
    add(0,  0, 0, 0, 0,                    0, 0,                      5,  0,   0, 5, 64'h1234,             1,  0, 0, 0, 0, 1);
    add(1,  1, 1, 0, 64'hA,                0, 0,                      1,  2,   1, 1, 64'hA,                1,  1, 0, 0, 0, 1);
    add(1,  2, 1, 0, 64'hB,                0, 0,                      1,  2,   1, 2, 64'hB,                1,  0, 0, 1, 0, 2);
    add(1,  3, 1, 0, 64'hC,                0, 0,                      3,  3,   1, 3, 64'hC,                1,  1, 0, 1, 0, 3);
    add(0,  0, 0, 0, 0,                    0, 0,                      3,  0,   0, 3, 64'hC,                1,  0, 0, 0, 0, 4);
    add(1,  7, 1, 1, 64'h55,               0, 0,                      7,  0,   0, 7, 0,                    0,  0, 1, 0, 0, 4);
    add(1,  7, 1, 1, 64'h55,               0, 0,                      7,  0,   0, 7, 0,                    0,  0, 1, 0, 0, 4);
    add(1,  7, 1, 1, 64'h55,               0, 0,                      0,  7,   0, 7, 0,                    0,  0, 0, 0, 1, 4);
    add(1,  7, 1, 1, 64'h55,               0, 0,                      7,  0,   0, 7, 0,                    0,  0, 1, 0, 0, 4);
    add(0,  0, 0, 0, 0,                    1, 64'hDEADBEEF_00000001,  7,  7,   1, 7, 64'hDEADBEEF_00000001, 1, 1, 0, 1, 0, 4);
    add(0,  0, 0, 0, 0,                    0, 0,                      7,  0,   0, 7, 64'hDEADBEEF_00000001, 1, 0, 0, 0, 0, 5);
    add(1, 31, 1, 0, 64'hFFFF,             0, 0,                     31, 31,   0,31, 64'hFFFF,             1,  0, 0, 0, 0, 5);
    add(0,  0, 0, 0, 0,                    1, 64'h99,                31,  0,   0,31, 64'hFFFF,             1,  0, 0, 0, 0, 6);
    add(0,  0, 0, 0, 0,                    1, 64'h77,                 0,  0,   0,31, 64'hFFFF,             1,  0, 0, 0, 0, 6);
    add(1,  4, 0, 1, 64'h42,               0, 0,                      4,  0,   0, 4, 64'h42,               1,  0, 0, 0, 0, 6);
    add(1,  9, 1, 0, 64'h900,              1, 64'h5,                  9,  0,   1, 9, 64'h900,              1,  1, 0, 0, 0, 7);
    add(1, 10, 1, 1, 64'h3,                0, 0,                     10,  9,   0,10, 0,                    0,  0, 1, 0, 0, 8);
    add(1, 10, 1, 1, 64'h3,                1, 64'h1010,              10, 10,   1,10, 64'h1010,             1,  1, 0, 1, 0, 8);
    add(0,  0, 0, 0, 0,                    0, 0,                      0,  0,   0,10, 64'h1010,             1,  0, 0, 0, 0, 9);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].rw, tbl[i].m2r, tbl[i].alu, tbl[i].rv, tbl[i].rdata,
            tbl[i].rs1, tbl[i].rs2);
      tick();
      check_all($sformatf("tbl%0d", i), tbl[i].e_we, tbl[i].e_wr, tbl[i].e_wd, tbl[i].e_rdy,
                tbl[i].e_h1, tbl[i].e_p1, tbl[i].e_h2, tbl[i].e_p2, tbl[i].e_cnt);
    end

    // Reset while a load is outstanding, followed by the late response.
    drive(1, 8, 1, 1, 64'h1, 0, 0, 8, 0);
    tick();
    check("rst_wait.pend", fwd_pend1, 1'b1);
    tick();
    reset = 1'b1;
    drive(1, 8, 1, 1, 64'h1, 1, 64'hBAD, 8, 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 64'hBAD2, 8, 0);
    tick();
    check_all("rst_wait", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 8, 0);
    tick();
    check_all("rst_wait2", 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Counter wrap: preload the count, then retire one op.
    drive(1, 6, 1, 0, 64'h66, 0, 0, 6, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 6, 0);
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    check("wrap.pre", retire_count, 32'hFFFF_FFFF);
    check("wrap.we", RegWrite, 1'b1);
    tick();
    check("wrap.post", retire_count, 32'd0);
    check("wrap.idle", RegWrite, 1'b0);

    // Randomized run against the reference model.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] r1, r2;
      r1 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(28, 31));
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            {$urandom, $urandom}, $urandom_range(0, 2) == 0, {$urandom, $urandom}, r1, r2);
      reset = ($urandom_range(0, 199) == 0);
      #1;
      if (!reset) model_check();
      model_edge();
      @(posedge clk);
      #1;
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
